// File: rtl/score_display_driver.sv
// Three-digit multiplexed seven-segment driver with leading-zero blanking and a game-over flash.
// Latency: one registered stage from digit index/latch to seg/an; no backpressure, free-running scan.
module score_display_driver #(
    parameter int SCAN_DIV     = 1000,
    parameter int FLASH_DIV    = 3000000,
    parameter int FLASH_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_hundreds,
    input  logic       isGameComplete,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       flashing
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(FLASH_DIV);
    localparam int HW = $clog2(2 * FLASH_CYCLES + 1);

    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * FLASH_CYCLES - 1);

    typedef enum logic [1:0] {LIVE, FLASH, HOLD} state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [SW-1:0] scan_cnt;
    logic [FW-1:0] flash_cnt;
    logic [HW-1:0] half_cnt;
    logic [3:0]    dig_o, dig_t, dig_h;

    logic [3:0]    cur_digit;
    logic          zero_blank;
    logic          visible;
    logic [6:0]    seg_next;
    logic [2:0]    an_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        cur_digit  = dig_o;
        zero_blank = 1'b0;
        case (idx)
            2'd1: begin
                cur_digit  = dig_t;
                zero_blank = (dig_h == 4'd0) && (dig_t == 4'd0);
            end
            2'd2: begin
                cur_digit  = dig_h;
                zero_blank = (dig_h == 4'd0);
            end
            default: begin
                cur_digit  = dig_o;
                zero_blank = 1'b0;
            end
        endcase
        // Even half-periods of the flash are the dark phase.
        visible  = !((state == FLASH) && !half_cnt[0]);
        an_next  = visible ? (3'b001 << idx) : 3'b000;
        seg_next = (visible && !zero_blank) ? decode(cur_digit) : 7'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LIVE;
            idx       <= 2'd0;
            scan_cnt  <= '0;
            flash_cnt <= '0;
            half_cnt  <= '0;
            dig_o     <= 4'd0;
            dig_t     <= 4'd0;
            dig_h     <= 4'd0;
            seg       <= 7'h00;
            an        <= 3'b000;
            flashing  <= 1'b0;
        end else begin
            seg <= seg_next;
            an  <= an_next;

            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            case (state)
                LIVE: begin
                    dig_o <= bcd_ones;
                    dig_t <= bcd_tens;
                    dig_h <= bcd_hundreds;
                    flash_cnt <= '0;
                    half_cnt  <= '0;
                    if (isGameComplete) begin
                        state    <= FLASH;
                        flashing <= 1'b1;
                    end else begin
                        flashing <= 1'b0;
                    end
                end
                FLASH: begin
                    // Latch stays frozen here so the final score is what flashes.
                    if (!isGameComplete) begin
                        state     <= LIVE;
                        flashing  <= 1'b0;
                        flash_cnt <= '0;
                        half_cnt  <= '0;
                    end else if (flash_cnt == FLASH_MAX) begin
                        flash_cnt <= '0;
                        if (half_cnt == HALF_LAST) begin
                            state    <= HOLD;
                            flashing <= 1'b0;
                            half_cnt <= '0;
                        end else begin
                            half_cnt <= half_cnt + 1'b1;
                        end
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    dig_o    <= bcd_ones;
                    dig_t    <= bcd_tens;
                    dig_h    <= bcd_hundreds;
                    flashing <= 1'b0;
                    if (!isGameComplete) state <= LIVE;
                end
                default: begin
                    state    <= LIVE;
                    flashing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_display_driver.sv
// Directed, table-driven bench for score_display_driver with small divisors.
module tb_score_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd_ones, bcd_tens, bcd_hundreds;
    logic       isGameComplete;
    logic [6:0] seg;
    logic [2:0] an;
    logic       flashing;

    int checks = 0;
    int errors = 0;

    score_display_driver #(.SCAN_DIV(4), .FLASH_DIV(8), .FLASH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .bcd_hundreds(bcd_hundreds),
        .isGameComplete(isGameComplete),
        .seg(seg), .an(an), .flashing(flashing)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         reps;
        logic [3:0] h, t, o;
        logic       igc;
        logic [2:0] an;
        logic [6:0] seg;
        logic       fl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int reps, input logic [3:0] h, t, o, input logic igc,
                       input logic [2:0] a, input logic [6:0] s, input logic fl);
        vec_t v;
        v.reps = reps; v.h = h; v.t = t; v.o = o; v.igc = igc;
        v.an = a; v.seg = s; v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] h, t, o, input logic igc);
        bcd_hundreds = h; bcd_tens = t; bcd_ones = o; isGameComplete = igc;
    endtask

    initial begin
        rst = 1'b1;
        drive(4'd1, 4'd2, 4'd3, 1'b0);
        repeat (3) step();
        chk("reset_seg", 32'(seg), 32'h00);
        chk("reset_an", 32'(an), 32'h0);
        chk("reset_flashing", 32'(flashing), 32'h0);
        rst = 1'b0;

        // scan 123, then blanking, invalid digit, then 045 before game over
        add(1, 1,2,3, 0, 3'b001, 7'h3F, 0);
        add(3, 1,2,3, 0, 3'b001, 7'h4F, 0);
        add(4, 1,2,3, 0, 3'b010, 7'h5B, 0);
        add(4, 1,2,3, 0, 3'b100, 7'h06, 0);
        add(1, 0,0,7, 0, 3'b001, 7'h4F, 0);
        add(3, 0,0,7, 0, 3'b001, 7'h07, 0);
        add(4, 0,0,7, 0, 3'b010, 7'h00, 0);
        add(4, 0,0,7, 0, 3'b100, 7'h00, 0);
        add(4, 0,0,7, 0, 3'b001, 7'h07, 0);
        add(4, 0,0,0, 0, 3'b010, 7'h00, 0);
        add(4, 0,0,0, 0, 3'b100, 7'h00, 0);
        add(4, 0,0,0, 0, 3'b001, 7'h3F, 0);
        add(1, 1,0,5, 0, 3'b010, 7'h00, 0);
        add(3, 1,0,5, 0, 3'b010, 7'h3F, 0);
        add(4, 1,0,5, 0, 3'b100, 7'h06, 0);
        add(4, 1,0,5, 0, 3'b001, 7'h6D, 0);
        add(4, 1,0,4'hC, 0, 3'b010, 7'h3F, 0);
        add(4, 1,0,4'hC, 0, 3'b100, 7'h06, 0);
        add(4, 1,0,4'hC, 0, 3'b001, 7'h40, 0);
        add(1, 0,4,5, 0, 3'b010, 7'h3F, 0);
        add(3, 0,4,5, 0, 3'b010, 7'h66, 0);
        add(4, 0,4,5, 0, 3'b100, 7'h00, 0);
        add(4, 0,4,5, 0, 3'b001, 7'h6D, 0);
        // game over: capture 099, blank/visible x2, inputs changed mid-flash
        add(1, 0,9,9, 1, 3'b010, 7'h66, 1);
        add(8, 0,9,9, 1, 3'b000, 7'h00, 1);
        add(3, 0,1,1, 1, 3'b001, 7'h6F, 1);
        add(4, 0,1,1, 1, 3'b010, 7'h6F, 1);
        add(1, 0,1,1, 1, 3'b100, 7'h00, 1);
        add(8, 0,1,1, 1, 3'b000, 7'h00, 1);
        add(3, 0,9,9, 1, 3'b010, 7'h6F, 1);
        add(4, 0,9,9, 1, 3'b100, 7'h00, 1);
        // HOLD: steady 99
        add(1, 0,9,9, 1, 3'b001, 7'h6F, 0);
        add(3, 0,9,9, 1, 3'b001, 7'h6F, 0);
        add(4, 0,9,9, 1, 3'b010, 7'h6F, 0);
        add(4, 0,9,9, 1, 3'b100, 7'h00, 0);
        add(4, 0,9,9, 0, 3'b001, 7'h6F, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].igc);
                step();
                chk($sformatf("vec%0d.%0d_an", i, r), 32'(an), 32'(vecs[i].an));
                chk($sformatf("vec%0d.%0d_seg", i, r), 32'(seg), 32'(vecs[i].seg));
                chk($sformatf("vec%0d.%0d_flashing", i, r), 32'(flashing), 32'(vecs[i].fl));
            end
        end

        // Abort during the first visible half-period
        drive(4'd0, 4'd9, 4'd9, 1'b1);
        step();
        chk("abort_entry_flashing", 32'(flashing), 32'h1);
        repeat (8) step();
        step();
        chk("abort_visible_an", 32'(an), 32'h1);
        chk("abort_visible_seg", 32'(seg), 32'h6F);
        drive(4'd0, 4'd1, 4'd1, 1'b0);
        step();
        chk("abort_flashing", 32'(flashing), 32'h0);
        step();
        chk("abort_frozen_an", 32'(an), 32'h1);
        chk("abort_frozen_seg", 32'(seg), 32'h6F);
        step();
        chk("abort_track_an", 32'(an), 32'h2);
        chk("abort_track_seg", 32'(seg), 32'h06);

        // Asynchronous reset in the middle of a flash
        isGameComplete = 1'b1;
        step();
        repeat (9) step();
        chk("pre_rst_flashing", 32'(flashing), 32'h1);
        chk("pre_rst_an", 32'(an), 32'h1);
        chk("pre_rst_seg", 32'(seg), 32'h06);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_seg", 32'(seg), 32'h00);
        chk("async_rst_an", 32'(an), 32'h0);
        chk("async_rst_flashing", 32'(flashing), 32'h0);
        isGameComplete = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_an", 32'(an), 32'h1);
        chk("post_rst_seg", 32'(seg), 32'h3F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
Downstream consumer of the score tracker's BCD digits and game-complete flag. Drives a 3-digit multiplexed seven-segment display with leading-zero blanking. On game over, it flashes the displayed (high) score for a fixed number of blink periods, then holds it steady until the next game starts.

Parameters:
SCAN_DIV, 1000, clocks each digit stays enabled per scan slot (>=2)
FLASH_DIV, 3000000, clocks per flash half-period (>=2)
FLASH_CYCLES, 3, number of full blank+visible blink periods after game over (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
bcd_ones  in  4  score ones digit
bcd_tens  in  4  score tens digit
bcd_hundreds  in  4  score hundreds digit
isGameComplete  in  1  level; high while game is over
seg  out  7  segments {g,f,e,d,c,b,a}, active-high
an  out  3  digit enables, one-hot active-high; [0]=ones, [1]=tens, [2]=hundreds
flashing  out  1  high while in FLASH state

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. Reset state: state=LIVE, digit index=0, all counters=0, digit latch=0, seg=7'h00, an=3'b000, flashing=0.
- First clock after reset release: an=3'b001, seg=7'h3F.
- Digit latch (3x4 bits):
  - LIVE and HOLD: loads bcd_* every clock.
  - FLASH: frozen at the value sampled on the edge that entered FLASH.
- Scan counter: counts 0..SCAN_DIV-1 and wraps. On wrap, digit index advances 0->1->2->0 (never 3).
- Outputs: seg and an are registered from the current index and latch. One-cycle latency from index/latch change to pins.
- Decode (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any digit value >9 shows dash 40.
- Leading-zero blanking:
  - Hundreds slot: seg=00 when hundreds==0.
  - Tens slot: seg=00 when hundreds==0 and tens==0.
  - Ones slot: never blanked, so score 0 shows a single "0".
  - The an bit still asserts during a blanked slot.
- FSM:
  - LIVE: normal scan. A rising edge of isGameComplete (sampled high while in LIVE) -> FLASH. Flash counter and half-count clear; latch captures.
  - FLASH: flash counter counts 0..FLASH_DIV-1 and wraps; each wrap increments half-count.
    - Even half-count: blank phase, an=000, seg=00.
    - Odd half-count: visible phase, normal scan.
    - After 2*FLASH_CYCLES halves complete -> HOLD.
    - isGameComplete low at any point -> LIVE immediately. Counters clear; latch resumes tracking next clock.
    - Scan counter keeps running during FLASH.
  - HOLD: steady scan. isGameComplete low -> LIVE.
- isGameComplete already high at reset release: LIVE samples it high -> FLASH on the first edge.
- flashing = registered (state==FLASH).
- Digit changes in LIVE: reflected on the next scan slot that selects that digit. No tearing within a slot beyond the one-cycle latch delay.
- Counter widths: $clog2 of the respective divisor. Half-count needs $clog2(2*FLASH_CYCLES+1) bits.

Test Plan:
- Use SCAN_DIV=4, FLASH_DIV=8, FLASH_CYCLES=2 for all scenarios.
- Reset and scan: hold rst 3 cycles, check seg=00 and an=000. Release with bcd=1,2,3 (hundreds,tens,ones). Check an sequence 001,010,100,001 with 4 cycles each, and seg=4F/5B/06 in the matching slots.
- Blanking: bcd=0,0,7 -> hundreds and tens slots seg=00 with an asserted, ones slot seg=07. Then bcd=0,0,0 -> ones slot shows 3F. Then bcd=1,0,5 -> tens slot shows 3F (not blanked).
- Invalid digit: ones=4'hC -> ones slot seg=40.
- Game over flash: LIVE showing 045. Same edge: isGameComplete=1 and bcd=0,9,9. Check:
  - flashing=1 next cycle.
  - an=000 for 8 cycles, then scan shows 99 for 8, blank 8, scan 8.
  - Then flashing=0 (HOLD) with steady 99.
  - Changing bcd mid-FLASH to 0,1,1 does not alter the display until HOLD.
- Abort: during FLASH half-count 1, drop isGameComplete -> next cycle state LIVE, flashing=0, latch tracks inputs on the following cycle.
- Async reset mid-FLASH: assert rst between clock edges -> seg=00, an=000, flashing=0 immediately, without waiting for a clock edge.
